// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
// Purpose: buffer entry layout, fetch FSM state encoding and the canonical NOP word.
// Ports: none (package).
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    typedef enum logic {
        FB_RUN   = 1'b0,
        FB_DRAIN = 1'b1
    } fb_state_t;

    localparam logic [31:0] FB_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
// Purpose: holds fetched {pc, word} pairs between the memory response bus and the core.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write one entry (accepted when not full, or when a pop happens the same cycle)
//   pop             remove head entry (ignored when empty)
//   flush           discard all entries; wins over push/pop
//   rdata           head entry
//   count           number of stored entries
//   empty, full     occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_do_pop;
    logic           w_do_push;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);

endmodule

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - prefetching instruction fetch stage with redirect flush
// Purpose: issues sequential word fetches under a credit limit, buffers returned words with
//   their PC and hands them to the core; redirects flush the buffer and drop stale responses.
// Build option: FETCH_BYPASS_EN - an empty buffer forwards a kept response to the core in the
//   same cycle (0-cycle latency); otherwise every kept response is buffered first.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   redirect, redirect_pc    flush and restart fetch at redirect_pc (word aligned)
//   req_valid/ready/addr     fetch request bus
//   rsp_valid, rsp_data      in-order response bus, no back-pressure
//   inst_valid/ready         instruction handshake to the core
//   inst, inst_pc            instruction word and its address
module inst_fetch_buf
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fb_state_t      r_state;
    fb_state_t      w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_rsp_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_drop_cnt;
    logic [CW-1:0]  w_drop_nxt;
    logic [CW-1:0]  w_n;
    logic [CW-1:0]  w_count;
    logic           w_empty;
    logic           w_full;
    logic           w_req_valid;
    logic           w_req_fire;
    logic           w_keep;
    logic           w_byp;
    logic           w_inst_valid;
    logic           w_push;
    logic           w_pop;
    fetch_entry_t   w_head;
    fetch_entry_t   w_wdata;

    // Credit: every request in flight already owns a buffer slot.
    assign w_req_valid = !rst && (r_state == FB_RUN)
                         && (({1'b0, r_outstanding} + {1'b0, w_count}) < DEPTH_W);
    assign w_req_fire  = w_req_valid && req_ready;

    // Requests still owed a response after this cycle; these are the stale ones on redirect.
    assign w_n = r_outstanding + CW'(w_req_fire) - CW'(rsp_valid);

    // A response in the redirect cycle belongs to the old stream and is always dropped.
    assign w_keep = rsp_valid && !redirect && (r_drop_cnt == '0);

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_keep && w_empty && (r_state == FB_RUN);
`else
    assign w_byp = 1'b0;
`endif

    assign w_inst_valid = !rst && (!w_empty || w_byp);
    assign w_pop        = w_inst_valid && inst_ready && !w_empty && !redirect;
    assign w_push       = w_keep && !(w_byp && inst_ready);
    assign w_wdata      = '{pc: r_rsp_pc, word: rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        if (redirect) begin
            w_drop_nxt  = w_n;
            w_state_nxt = (w_n != '0) ? FB_DRAIN : FB_RUN;
        end else if (r_state == FB_DRAIN) begin
            if (rsp_valid && (r_drop_cnt != '0)) w_drop_nxt = r_drop_cnt - CW'(1);
            if ((r_drop_cnt == '0) || ((r_drop_cnt == CW'(1)) && rsp_valid)) w_state_nxt = FB_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FB_RUN;
            r_drop_cnt    <= '0;
            r_outstanding <= '0;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_drop_cnt    <= w_drop_nxt;
            r_outstanding <= w_n;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_keep)     r_rsp_pc   <= r_rsp_pc + 32'd4;
            end
        end
    end

    assign req_valid  = w_req_valid;
    assign req_addr   = r_fetch_pc;
    assign inst_valid = w_inst_valid;
    // When empty, r_rsp_pc is exactly the PC of a bypassed response.
    assign inst       = !w_empty ? w_head.word : (w_byp ? rsp_data : 32'h0);
    assign inst_pc    = !w_empty ? w_head.pc : r_rsp_pc;

    a_redirect_aligned: assert property (@(posedge clk) disable iff (rst)
        redirect |-> (redirect_pc[1:0] == 2'b00));
    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (r_outstanding != '0));
    a_rsp_has_slot: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (!w_full || w_pop));

endmodule
